top_level: RTL and testbench

- Hardwired decrypt-and-depad engine with its own 256x8 data memory.
- Reads a 64-byte encrypted message, then decrypts it with a 7-bit LFSR keystream.
- Strips the preamble and leading spaces, and flags bytes that fail the parity check.
- Writes the result back into low memory; a simple req/ack handshake starts the run and reports completion.

---
 rtl/top_level.sv | 149 ++++++++++++++
 tb/tb_top_level.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/top_level.sv
// Decrypt-and-depad engine with a private 256x8 data memory (DM).
// Latency: req low -> ack high in 3 + 64 + (64 - kept) + 2 cycles, at most 133.
// Backpressure: none inside a run; req high holds IDLE, and DONE holds ack until req rises.
module top_level_dm #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdat,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdat
);
  logic [7:0] core [0:DEPTH-1];

  assign rdat = core[raddr];

  always_ff @(posedge clk) begin
    if (we) core[waddr] <= wdat;
  end
endmodule

module top_level #(
  parameter int MSG_LEN  = 64,
  parameter int DM_DEPTH = 256
) (
  input  logic clk,
  input  logic init,
  input  logic req,
  output logic ack
);
  localparam int IW = $clog2(MSG_LEN);
  localparam int AW = $clog2(DM_DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, FILL, DONE} state_t;

  state_t        state, next;
  logic [1:0]    load_cnt;
  logic [IW-1:0] i;
  logic [IW:0]   w;
  logic [7:0]    pre_len;
  logic [6:0]    ptrn;
  logic [6:0]    lfsr;
  logic          leading;

  logic          we;
  logic [AW-1:0] waddr, raddr;
  logic [7:0]    wdat, rdat;

  logic          perr;
  logic [6:0]    p;
  logic          skip;

  top_level_dm #(.DEPTH(DM_DEPTH), .AW(AW)) DM (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdat  (wdat),
    .raddr (raddr),
    .rdat  (rdat)
  );

  assign perr = ^rdat;
  assign p    = rdat[6:0] ^ lfsr;
  // A parity-failed byte is never treated as a leading space, so it ends stripping.
  assign skip = (8'(i) < pre_len) || (leading && (p == 7'd0) && !perr);

  always_ff @(posedge clk) begin
    if (init) begin
      state <= IDLE;
      ack   <= 1'b0;
    end else begin
      state <= next;
      ack   <= (next == DONE);
    end
  end

  always_comb begin
    next = state;
    case (state)
      IDLE: if (!req) next = LOAD;
      LOAD: if (load_cnt == 2'd2) next = RUN;
      RUN:  if (i == IW'(MSG_LEN - 1)) next = FILL;
      FILL: if (w[IW]) next = DONE;
      DONE: if (req) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdat  = '0;
    raddr = '0;
    case (state)
      LOAD: raddr = AW'(MSG_LEN - 3) + AW'(load_cnt);
      RUN: begin
        raddr = AW'(MSG_LEN) + AW'(i);
        we    = !skip;
        waddr = AW'(w);
        wdat  = {perr, p};
      end
      FILL: begin
        we    = !w[IW];
        waddr = AW'(w);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) begin
      load_cnt <= '0;
      i        <= '0;
      w        <= '0;
      leading  <= 1'b1;
      pre_len  <= '0;
      ptrn     <= '0;
      lfsr     <= '0;
    end else begin
      case (state)
        IDLE: load_cnt <= '0;
        LOAD: begin
          load_cnt <= load_cnt + 2'd1;
          i        <= '0;
          w        <= '0;
          leading  <= 1'b1;
          // One parameter byte per LOAD cycle through the single read port.
          case (load_cnt)
            2'd0:    pre_len <= rdat;
            2'd1:    ptrn    <= rdat[6:0];
            default: lfsr    <= rdat[6:0];
          endcase
        end
        RUN: begin
          lfsr <= {lfsr[5:0], ^(lfsr & ptrn)};
          i    <= i + 1'b1;
          if (!skip) begin
            w       <= w + 1'b1;
            leading <= 1'b0;
          end
        end
        FILL: if (!w[IW]) w <= w + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_top_level.sv
// Bench for top_level: directed scenarios plus randomized messages against a byte-level model.
module tb_top_level;
  logic clk = 1'b0;
  logic init;
  logic req;
  logic ack;

  int checks = 0;
  int errors = 0;

  top_level dut (.clk(clk), .init(init), .req(req), .ack(ack));

  always #5 clk = ~clk;

  logic [7:0] msg  [64];
  logic [7:0] enc  [64];
  logic [6:0] ks   [64];
  logic [7:0] expv [64];
  logic [7:0] snap [64];
  logic [6:0] taps [9];
  int         kept;
  int         cur_pre;
  logic [6:0] cur_ptrn, cur_seed;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_msg(input string s, input int pre);
    for (int k = 0; k < 64; k++) begin
      if (k < pre) msg[k] = 8'h5F;
      else if (k - pre < s.len()) msg[k] = s[k - pre];
      else msg[k] = 8'h20;
    end
    cur_pre = pre;
  endtask

  // Encrypt the plaintext with even overall parity per byte.
  task automatic encrypt(input logic [6:0] ptrn, input logic [6:0] seed);
    logic [6:0] r, e;
    r = seed;
    for (int k = 0; k < 64; k++) begin
      ks[k]  = r;
      e      = 7'(msg[k] - 8'h20) ^ r;
      enc[k] = {^e, e};
      r      = {r[5:0], ^(r & ptrn)};
    end
    cur_ptrn = ptrn;
    cur_seed = seed;
  endtask

  task automatic model();
    logic [7:0] q [$];
    logic       lead, pe;
    logic [6:0] pp;
    lead = 1'b1;
    for (int k = 0; k < 64; k++) begin
      pe = ^enc[k];
      pp = enc[k][6:0] ^ ks[k];
      if (k < cur_pre) continue;
      if (lead && pp == 7'd0 && !pe) continue;
      q.push_back({pe, pp});
      lead = 1'b0;
    end
    kept = q.size();
    for (int k = 0; k < 64; k++) expv[k] = (k < kept) ? q[k] : 8'h00;
  endtask

  task automatic load_mem();
    for (int a = 0; a < 61; a++) dut.DM.core[a] = 8'hEE;
    dut.DM.core[61] = 8'(cur_pre);
    dut.DM.core[62] = {1'b0, cur_ptrn};
    dut.DM.core[63] = {1'b0, cur_seed};
    for (int k = 0; k < 64; k++) dut.DM.core[64 + k] = enc[k];
  endtask

  task automatic take_snap();
    for (int a = 0; a < 64; a++) snap[a] = dut.DM.core[a];
  endtask

  task automatic cmp_snap(input string tag);
    int bad;
    bad = 0;
    for (int a = 0; a < 64; a++) if (dut.DM.core[a] !== snap[a]) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic run(input string tag, output int lat);
    int bad, first;
    model();
    @(negedge clk);
    load_mem();
    req = 1'b0;
    lat = 0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ack === 1'b1) break;
    end
    chk({tag, " ack"}, ack, 1'b1);
    chk({tag, " latency"}, lat, 69 + 64 - kept);
    bad = 0;
    first = -1;
    for (int a = 0; a < 64; a++) begin
      if (dut.DM.core[a] !== expv[a]) begin
        bad++;
        if (first < 0) first = a;
      end
    end
    chk($sformatf("%s mem mismatches (first idx %0d)", tag, first), bad, 0);
    req = 1'b1;
    @(negedge clk);
    chk({tag, " ack drop"}, ack, 1'b0);
  endtask

  initial begin
    int lat, ack_seen, len;
    taps[0] = 7'h60; taps[1] = 7'h48; taps[2] = 7'h78;
    taps[3] = 7'h72; taps[4] = 7'h6A; taps[5] = 7'h69;
    taps[6] = 7'h5C; taps[7] = 7'h7E; taps[8] = 7'h7B;

    init = 1'b1;
    req  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ack", ack, 1'b0);
    init = 1'b0;

    // req held high: engine must stay idle
    set_msg("Mr. Watson, come here. I want to see you.", 10);
    encrypt(7'h60, 7'h01);
    load_mem();
    take_snap();
    ack_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack !== 1'b0) ack_seen++;
    end
    chk("hold ack", ack_seen, 0);
    cmp_snap("hold mem");

    run("plain", lat);
    chk("plain core0", dut.DM.core[0], 8'h2D);
    chk("plain core1", dut.DM.core[1], 8'h52);
    chk("plain core41", dut.DM.core[41], 8'h00);

    set_msg(" Knowledge comes, but wisdom lingers.", 15);
    encrypt(7'h7B, 7'h01);
    run("leading", lat);
    chk("leading core0", dut.DM.core[0], 8'h2B);

    set_msg("Mr. Watson, come here. I want to see you.", 10);
    encrypt(7'h60, 7'h01);
    enc[30] = enc[30] ^ 8'h08;
    run("corrupt", lat);
    chk("corrupt flag", dut.DM.core[20][7], 1'b1);
    chk("corrupt neighbour", dut.DM.core[19], 8'(msg[29] - 8'h20));

    set_msg("", 10);
    encrypt(7'h48, 7'h2A);
    run("allspace", lat);
    chk("allspace latency", lat, 133);

    // init mid-run leaves the FSM idle with no further writes
    set_msg("Elementary, my dear fellow.", 12);
    encrypt(7'h72, 7'h15);
    @(negedge clk);
    load_mem();
    req = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    init = 1'b1;
    req  = 1'b1;
    @(negedge clk);
    init = 1'b0;
    chk("init ack", ack, 1'b0);
    take_snap();
    ack_seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (ack !== 1'b0) ack_seen++;
    end
    chk("init idle ack", ack_seen, 0);
    cmp_snap("init idle mem");
    run("rerun", lat);

    for (int t = 0; t < 9; t++) begin
      len = $urandom_range(0, 48);
      cur_pre = $urandom_range(10, 15);
      for (int k = 0; k < 64; k++) begin
        if (k < cur_pre) msg[k] = 8'h5F;
        else if (k - cur_pre < len) msg[k] = 8'($urandom_range(32, 126));
        else msg[k] = 8'h20;
      end
      encrypt(taps[t], 7'($urandom_range(1, 127)));
      if ($urandom_range(0, 1) == 1) enc[$urandom_range(0, 63)] ^= 8'h04;
      run($sformatf("tap%0d", t), lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
